frog_position_ctrl: RTL and testbench

Converts the four player push-buttons into a frog cell position on the 20×15 grid of 32×32-pixel cells drawn by the VGA display stage. It sits directly upstream of the display: it synchronises and debounces the buttons, then moves the frog one cell per accepted press. It commits each move only on a frame-start strobe, so the display never changes the frog position mid-frame.

---
 rtl/frog_position_ctrl_if.sv | 40 ++++
 rtl/frog_position_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_frog_position_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/frog_position_ctrl_if.sv
// -----------------------------------------------------------------------------
// frog_position_ctrl_if
//
// Bundles the player-facing signals of frog_position_ctrl: the four raw
// push-buttons and the frame-start strobe going in, and the registered frog
// position plus event pulses coming out.
//
// Signals:
//   i_Switch_1..4  raw active-high buttons (up, down, left, right)
//   i_Frame_Start  one-cycle strobe at pixel (0,0) of each frame
//   o_Frog_Col     current column
//   o_Frog_Row     current row
//   o_Move         one-cycle pulse when the position changes
//   o_Home         one-cycle pulse when a move lands on row 0
//
// Modports:
//   master  the side that drives buttons/strobe and observes the position
//   slave   the position controller itself
// -----------------------------------------------------------------------------
interface frog_position_ctrl_if;
  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       i_Switch_3;
  logic       i_Switch_4;
  logic       i_Frame_Start;
  logic [4:0] o_Frog_Col;
  logic [3:0] o_Frog_Row;
  logic       o_Move;
  logic       o_Home;

  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4, i_Frame_Start,
    input  o_Frog_Col, o_Frog_Row, o_Move, o_Home
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4, i_Frame_Start,
    output o_Frog_Col, o_Frog_Row, o_Move, o_Home
  );
endinterface

// File: rtl/frog_position_ctrl.sv
// -----------------------------------------------------------------------------
// frog_position_ctrl
//
// Turns four raw player buttons into a frog cell position on the display
// grid. Buttons are synchronised (2 flops) and debounced; each accepted press
// moves the frog by one cell, committed only on the frame-start strobe so the
// display never sees the position change mid-frame. A held button never
// auto-repeats: the button set must be released and stay low for a full
// debounce interval before the next press is considered.
//
// Ports:
//   i_Clk    pixel clock (same clock as the display stage)
//   i_Rst_n  asynchronous active-low reset
//   bus      frog_position_ctrl_if.slave
//              i_Switch_1..4 (up/down/left/right), i_Frame_Start in
//              o_Frog_Col, o_Frog_Row, o_Move, o_Home out (all registered)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles to accept a press or release (>= 2)
//   GRID_COLS/ROWS   grid size
//   START_COL/ROW    position after reset
//
// Configuration macro:
//   FROG_POS_WRAP_EN  defined   -> moves wrap around the grid edges
//                     undefined -> moves clamp at the edges (no move, no pulse)
// -----------------------------------------------------------------------------
module frog_position_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRID_COLS       = 20,
  parameter int GRID_ROWS       = 15,
  parameter int START_COL       = 10,
  parameter int START_ROW       = 14
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  frog_position_ctrl_if.slave  bus
);

  localparam int COL_W = 5;
  localparam int ROW_W = 4;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(GRID_ROWS - 1);
  localparam logic [COL_W-1:0] COL_RESET = COL_W'(START_COL);
  localparam logic [ROW_W-1:0] ROW_RESET = ROW_W'(START_ROW);

`ifdef FROG_POS_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PENDING,
    S_RELEASE
  } state_t;

  // Encoding doubles as the bit index into the synchronised button vector.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // ---------------------------------------------------------------------------
  // Button synchroniser
  // ---------------------------------------------------------------------------
  logic [3:0] sw_raw;
  logic [3:0] sw_meta_q;
  logic [3:0] sw_sync_q;

  assign sw_raw = {bus.i_Switch_4, bus.i_Switch_3, bus.i_Switch_2, bus.i_Switch_1};

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of the others, independent of statement
  // order; blocking assignments here would collapse the two sync stages.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_raw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  dir_t               dir_q,   dir_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [COL_W-1:0]   col_q,   col_d;
  logic [ROW_W-1:0]   row_q,   row_d;
  logic               move_q,  move_d;
  logic               home_q,  home_d;

  logic               any_sw;
  logic               latched_sw;
  logic               cnt_done;
  logic [COL_W-1:0]   tgt_col;
  logic [ROW_W-1:0]   tgt_row;
  logic               tgt_changed;

  assign any_sw     = |sw_sync_q;
  assign latched_sw = sw_sync_q[dir_q];
  assign cnt_done   = (cnt_q == CNT_LAST);

  // Fixed priority up > down > left > right.
  function automatic dir_t pick_dir(input logic [3:0] sw);
    if (sw[0])      return DIR_UP;
    else if (sw[1]) return DIR_DOWN;
    else if (sw[2]) return DIR_LEFT;
    else            return DIR_RIGHT;
  endfunction

  // ---------------------------------------------------------------------------
  // Target cell for the latched direction (clamp or wrap at the edges)
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    tgt_col = col_q;
    tgt_row = row_q;
    case (dir_q)
      DIR_UP: begin
        if (row_q != '0)  tgt_row = row_q - 4'd1;
        else if (WRAP_EN) tgt_row = ROW_LAST;
      end
      DIR_DOWN: begin
        if (row_q != ROW_LAST) tgt_row = row_q + 4'd1;
        else if (WRAP_EN)      tgt_row = '0;
      end
      DIR_LEFT: begin
        if (col_q != '0)  tgt_col = col_q - 5'd1;
        else if (WRAP_EN) tgt_col = COL_LAST;
      end
      DIR_RIGHT: begin
        if (col_q != COL_LAST) tgt_col = col_q + 5'd1;
        else if (WRAP_EN)      tgt_col = '0;
      end
      default: ;
    endcase
  end

  assign tgt_changed = (tgt_col != col_q) || (tgt_row != row_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_sw) state_d = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!latched_sw)  state_d = S_IDLE;
        else if (cnt_done) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (bus.i_Frame_Start) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!any_sw && cnt_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next values
  // The counter only advances while below CNT_LAST, so it saturates rather
  // than wrapping even if a state lingers.
  // ---------------------------------------------------------------------------
  always_comb begin
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    col_d  = col_q;
    row_d  = row_q;
    move_d = 1'b0;
    home_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_sw) begin
          dir_d = pick_dir(sw_sync_q);
          cnt_d = '0;
        end
      end
      S_DEBOUNCE: begin
        if (latched_sw && !cnt_done) cnt_d = cnt_q + 1'b1;
      end
      S_PENDING: begin
        // Buttons are ignored here; the move commits only at frame start.
        if (bus.i_Frame_Start) begin
          col_d  = tgt_col;
          row_d  = tgt_row;
          move_d = tgt_changed;
          home_d = tgt_changed && (tgt_row == '0);
          cnt_d  = '0;
        end
      end
      S_RELEASE: begin
        if (any_sw)        cnt_d = '0;
        else if (!cnt_done) cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      dir_q  <= DIR_UP;
      cnt_q  <= '0;
      col_q  <= COL_RESET;
      row_q  <= ROW_RESET;
      move_q <= 1'b0;
      home_q <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      col_q  <= col_d;
      row_q  <= row_d;
      move_q <= move_d;
      home_q <= home_d;
    end
  end

  assign bus.o_Frog_Col = col_q;
  assign bus.o_Frog_Row = row_q;
  assign bus.o_Move     = move_q;
  assign bus.o_Home     = home_q;

endmodule

// File: tb/tb_frog_position_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frog_position_ctrl
//
// Directed bench for frog_position_ctrl with DEBOUNCE_CYCLES = 4. A table of
// single presses is applied in a loop, followed by hand-written sequences for
// glitches, held buttons, the top-row boundary and reset during a pending move.
// Button vector bit order: [0] up, [1] down, [2] left, [3] right.
// -----------------------------------------------------------------------------
module tb_frog_position_ctrl;

  logic clk;
  logic rst_n;

  frog_position_ctrl_if bus ();

  frog_position_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .GRID_COLS       (20),
    .GRID_ROWS       (15),
    .START_COL       (10),
    .START_ROW       (14)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int move_cnt  = 0;

  // Counts every cycle o_Move is seen high, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.o_Move === 1'b1) move_cnt++;
  end

  typedef struct {
    string      name;
    logic [3:0] sw;
    logic [4:0] exp_col;
    logic [3:0] exp_row;
    logic       exp_move;
    logic       exp_home;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [3:0] sw);
    bus.i_Switch_1 = sw[0];
    bus.i_Switch_2 = sw[1];
    bus.i_Switch_3 = sw[2];
    bus.i_Switch_4 = sw[3];
  endtask

  task automatic strobe();
    bus.i_Frame_Start = 1'b1;
    tick();
    bus.i_Frame_Start = 1'b0;
  endtask

  task automatic do_reset();
    set_sw(4'b0000);
    bus.i_Frame_Start = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Hold the buttons long enough to reach the pending state, release, then
  // strobe frame start. Outputs reflect the committed move on return.
  task automatic press(input logic [3:0] sw);
    set_sw(sw);
    repeat (10) tick();
    set_sw(4'b0000);
    strobe();
  endtask

  task automatic settle();
    repeat (10) tick();
  endtask

  int moves_before;

  initial begin
    set_sw(4'b0000);
    bus.i_Frame_Start = 1'b0;
    rst_n = 1'b1;

    // Expected results for consecutive presses starting from (10,14).
    vecs[0] = '{"up",            4'b0001, 5'd10, 4'd13, 1'b1, 1'b0};
    vecs[1] = '{"up_and_right",  4'b1001, 5'd10, 4'd12, 1'b1, 1'b0};
    vecs[2] = '{"down",          4'b0010, 5'd10, 4'd13, 1'b1, 1'b0};
    vecs[3] = '{"left",          4'b0100, 5'd9,  4'd13, 1'b1, 1'b0};
    vecs[4] = '{"right",         4'b1000, 5'd10, 4'd13, 1'b1, 1'b0};
    vecs[5] = '{"down_and_left", 4'b0110, 5'd10, 4'd14, 1'b1, 1'b0};
    vecs[6] = '{"left_and_right",4'b1100, 5'd9,  4'd14, 1'b1, 1'b0};
`ifdef FROG_POS_WRAP_EN
    vecs[7] = '{"down_bottom",   4'b0010, 5'd9,  4'd0,  1'b1, 1'b1};
`else
    vecs[7] = '{"down_bottom",   4'b0010, 5'd9,  4'd14, 1'b0, 1'b0};
`endif

    // ---- reset state
    do_reset();
    check("reset_col",  32'(bus.o_Frog_Col), 32'd10);
    check("reset_row",  32'(bus.o_Frog_Row), 32'd14);
    check("reset_move", 32'(bus.o_Move),     32'd0);
    check("reset_home", 32'(bus.o_Home),     32'd0);

    // ---- table-driven single presses
    for (int i = 0; i < 8; i++) begin
      press(vecs[i].sw);
      check({vecs[i].name, "_col"},  32'(bus.o_Frog_Col), 32'(vecs[i].exp_col));
      check({vecs[i].name, "_row"},  32'(bus.o_Frog_Row), 32'(vecs[i].exp_row));
      check({vecs[i].name, "_move"}, 32'(bus.o_Move),     32'(vecs[i].exp_move));
      check({vecs[i].name, "_home"}, 32'(bus.o_Home),     32'(vecs[i].exp_home));
      tick();
      check({vecs[i].name, "_move_1cyc"}, 32'(bus.o_Move), 32'd0);
      settle();
    end

    // ---- glitch: right for 2 cycles never reaches pending
    do_reset();
    moves_before = move_cnt;
    set_sw(4'b1000);
    repeat (2) tick();
    set_sw(4'b0000);
    repeat (3) begin
      repeat (8) tick();
      strobe();
    end
    tick();
    check("glitch_moves", 32'(move_cnt - moves_before), 32'd0);
    check("glitch_col",   32'(bus.o_Frog_Col), 32'd10);
    // Back in idle: a proper press is accepted right away.
    press(4'b0001);
    check("after_glitch_row", 32'(bus.o_Frog_Row), 32'd13);
    settle();

    // ---- held left across 5 strobes: exactly one move
    do_reset();
    moves_before = move_cnt;
    set_sw(4'b0100);
    repeat (5) begin
      repeat (12) tick();
      strobe();
    end
    tick();
    check("held_moves", 32'(move_cnt - moves_before), 32'd1);
    check("held_col",   32'(bus.o_Frog_Col), 32'd9);
    // Release, allow the release debounce, press again.
    set_sw(4'b0000);
    repeat (6) tick();
    press(4'b0100);
    check("repress_col",  32'(bus.o_Frog_Col), 32'd8);
    check("repress_move", 32'(bus.o_Move),     32'd1);
    settle();

    // ---- 14 ups reach row 0, home only on the last
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      press(4'b0001);
      check($sformatf("up%0d_row", i),  32'(bus.o_Frog_Row), 32'(14 - i));
      check($sformatf("up%0d_move", i), 32'(bus.o_Move),     32'd1);
      check($sformatf("up%0d_home", i), 32'(bus.o_Home),     (i == 14) ? 32'd1 : 32'd0);
      settle();
    end
    press(4'b0001);
`ifdef FROG_POS_WRAP_EN
    check("up15_row",  32'(bus.o_Frog_Row), 32'd14);
    check("up15_move", 32'(bus.o_Move),     32'd1);
`else
    check("up15_row",  32'(bus.o_Frog_Row), 32'd0);
    check("up15_move", 32'(bus.o_Move),     32'd0);
`endif
    check("up15_home", 32'(bus.o_Home), 32'd0);
    settle();

    // ---- reset while a down move is pending
    do_reset();
    press(4'b0001);
    check("pre_pending_row", 32'(bus.o_Frog_Row), 32'd13);
    settle();
    set_sw(4'b0010);
    repeat (10) tick();
    set_sw(4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pending_col",  32'(bus.o_Frog_Col), 32'd10);
    check("rst_pending_row",  32'(bus.o_Frog_Row), 32'd14);
    check("rst_pending_move", 32'(bus.o_Move),     32'd0);
    tick();
    rst_n = 1'b1;
    moves_before = move_cnt;
    repeat (3) begin
      repeat (6) tick();
      strobe();
    end
    tick();
    check("rst_pending_moves", 32'(move_cnt - moves_before), 32'd0);
    check("rst_pending_row2",  32'(bus.o_Frog_Row), 32'd14);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
